// File: rtl/edge_counter_bank.sv
// Multi-channel push-button event counter: per channel a 2-FF synchroniser,
// debounce FSM (with bypass), mode-selected edge detector and mod-MOD counter.
module edge_counter_bank #(
    parameter int N_CH       = 2,
    parameter int MOD        = 10,
    parameter int CNT_W      = 4,
    parameter int DB_TICKS   = 500000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_CH-1:0]         sw,
    input  logic [2*N_CH-1:0]       mode,
    input  logic [N_CH-1:0]         db_en,
    input  logic [N_CH-1:0]         clr,
    output logic [N_CH-1:0]         level,
    output logic [N_CH-1:0]         tick,
    output logic [N_CH-1:0]         wrap,
    output logic [N_CH*CNT_W-1:0]   count_flat
);

    localparam int              TMR_W    = $clog2(DB_TICKS + 1);
    localparam logic [TMR_W-1:0] DB_LAST  = TMR_W'(DB_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOD - 1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } db_state_t;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic             sync_q1;
        logic             sync_q2;
        logic             s;
        db_state_t        state_q;
        db_state_t        state_d;
        logic [TMR_W-1:0] timer_q;
        logic [TMR_W-1:0] timer_d;
        logic             lvl_q;
        logic             lvl_d;
        logic             lvl_dly;
        logic             rise;
        logic             fall;
        logic             tick_c;
        logic             wrap_c;
        logic [CNT_W-1:0] cnt_q;

        // Sync flops reset to the raw idle level so s comes out of reset inactive.
        // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sync_q1 <= ACTIVE_LOW;
                sync_q2 <= ACTIVE_LOW;
            end else begin
                sync_q1 <= sw[i];
                sync_q2 <= sync_q1;
            end
        end

        assign s = sync_q2 ^ ACTIVE_LOW;

        // NOTE: every output of this block gets a default first, so no latch is inferred.
        always_comb begin
            state_d = state_q;
            timer_d = timer_q;
            lvl_d   = lvl_q;
            if (!db_en[i]) begin
                timer_d = '0;
                // A pending wait is dropped without touching the level this cycle.
                if (state_q == WAIT_HI || state_q == WAIT_LO) begin
                    state_d = lvl_q ? STABLE_HI : STABLE_LO;
                end else begin
                    lvl_d   = s;
                    state_d = s ? STABLE_HI : STABLE_LO;
                end
            end else begin
                case (state_q)
                    STABLE_LO: begin
                        if (s) begin
                            state_d = WAIT_HI;
                            timer_d = TMR_W'(1);
                        end
                    end
                    WAIT_HI: begin
                        if (!s) begin
                            state_d = STABLE_LO;
                            timer_d = '0;
                        end else if (timer_q == DB_LAST) begin
                            state_d = STABLE_HI;
                            timer_d = '0;
                            lvl_d   = 1'b1;
                        end else begin
                            timer_d = timer_q + TMR_W'(1);
                        end
                    end
                    STABLE_HI: begin
                        if (!s) begin
                            state_d = WAIT_LO;
                            timer_d = TMR_W'(1);
                        end
                    end
                    WAIT_LO: begin
                        if (s) begin
                            state_d = STABLE_HI;
                            timer_d = '0;
                        end else if (timer_q == DB_LAST) begin
                            state_d = STABLE_LO;
                            timer_d = '0;
                            lvl_d   = 1'b0;
                        end else begin
                            timer_d = timer_q + TMR_W'(1);
                        end
                    end
                    default: begin
                        state_d = STABLE_LO;
                        timer_d = '0;
                    end
                endcase
            end
        end

        assign rise   = lvl_q & ~lvl_dly;
        assign fall   = ~lvl_q & lvl_dly;
        assign tick_c = (mode[2*i] & rise) | (mode[2*i+1] & fall);
        assign wrap_c = tick_c & ~clr[i] & (cnt_q == CNT_LAST);

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state_q <= STABLE_LO;
                timer_q <= '0;
                lvl_q   <= 1'b0;
                lvl_dly <= 1'b0;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                timer_q <= timer_d;
                lvl_q   <= lvl_d;
                lvl_dly <= lvl_q;
                // Clear wins over a coincident tick and suppresses the wrap.
                if (clr[i]) begin
                    cnt_q <= '0;
                end else if (tick_c) begin
                    cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
                end
            end
        end

        assign level[i]                   = lvl_q;
        assign tick[i]                    = tick_c;
        assign wrap[i]                    = wrap_c;
        assign count_flat[CNT_W*i +: CNT_W] = cnt_q;
    end

endmodule

// File: tb/tb_edge_counter_bank.sv
// Self-checking bench for edge_counter_bank: directed scenarios with literal
// expectations plus randomized traffic compared each cycle against a behavioural model.
module tb_edge_counter_bank;

    localparam int N_CH       = 2;
    localparam int MOD        = 10;
    localparam int CNT_W      = 4;
    localparam int DB_TICKS   = 4;
    localparam bit ACTIVE_LOW = 1'b1;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [N_CH-1:0]       sw;
    logic [2*N_CH-1:0]     mode;
    logic [N_CH-1:0]       db_en;
    logic [N_CH-1:0]       clr;
    logic [N_CH-1:0]       level;
    logic [N_CH-1:0]       tick;
    logic [N_CH-1:0]       wrap;
    logic [N_CH*CNT_W-1:0] count_flat;

    edge_counter_bank #(
        .N_CH(N_CH), .MOD(MOD), .CNT_W(CNT_W), .DB_TICKS(DB_TICKS), .ACTIVE_LOW(ACTIVE_LOW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .mode(mode), .db_en(db_en), .clr(clr),
        .level(level), .tick(tick), .wrap(wrap), .count_flat(count_flat)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int unsigned actual, input int unsigned expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Behavioural model: raw delay line, a run-length debounce and a modulo counter.
    bit  m_raw [N_CH][2];
    int  m_run [N_CH];
    bit  m_lvl [N_CH];
    bit  m_prev[N_CH];
    int  m_cnt [N_CH];
    bit  model_started = 1'b0;

    function automatic bit exp_tick(input int ch);
        bit rose;
        bit fell;
        rose = !m_prev[ch] && m_lvl[ch];
        fell = m_prev[ch] && !m_lvl[ch];
        return (mode[2*ch] && rose) || (mode[2*ch+1] && fell);
    endfunction

    always @(posedge clk) begin
        for (int ch = 0; ch < N_CH; ch++) begin
            if (!rst_n) begin
                m_raw[ch][0] = ACTIVE_LOW;
                m_raw[ch][1] = ACTIVE_LOW;
                m_run[ch]    = 0;
                m_lvl[ch]    = 1'b0;
                m_prev[ch]   = 1'b0;
                m_cnt[ch]    = 0;
            end else begin
                bit s_now;
                s_now = m_raw[ch][1] ^ ACTIVE_LOW;
                if (clr[ch])           m_cnt[ch] = 0;
                else if (exp_tick(ch)) m_cnt[ch] = (m_cnt[ch] + 1) % MOD;
                m_prev[ch] = m_lvl[ch];
                if (db_en[ch]) begin
                    // A new level is taken once it has been seen DB_TICKS+1 samples in a row.
                    if (s_now == m_lvl[ch]) m_run[ch] = 0;
                    else                    m_run[ch] = m_run[ch] + 1;
                    if (m_run[ch] == DB_TICKS + 1) begin
                        m_lvl[ch] = s_now;
                        m_run[ch] = 0;
                    end
                end else if (m_run[ch] > 0) begin
                    m_run[ch] = 0;
                end else begin
                    m_lvl[ch] = s_now;
                end
                m_raw[ch][1] = m_raw[ch][0];
                m_raw[ch][0] = sw[ch];
            end
        end
        model_started = 1'b1;
    end

    int obs_tick  [N_CH];
    int obs_wrap  [N_CH];
    int obs_lvl_hi[N_CH];

    always @(negedge clk) begin
        if (model_started) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                bit et;
                bit ew;
                et = exp_tick(ch);
                ew = et && !clr[ch] && (m_cnt[ch] == MOD - 1);
                check($sformatf("level ch%0d t=%0t", ch, $time), level[ch], m_lvl[ch]);
                check($sformatf("tick ch%0d t=%0t", ch, $time), tick[ch], et);
                check($sformatf("wrap ch%0d t=%0t", ch, $time), wrap[ch], ew);
                check($sformatf("count ch%0d t=%0t", ch, $time),
                      count_flat[CNT_W*ch +: CNT_W], m_cnt[ch]);
                obs_tick[ch]   += int'(tick[ch]);
                obs_wrap[ch]   += int'(wrap[ch]);
                obs_lvl_hi[ch] += int'(level[ch]);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        for (int ch = 0; ch < N_CH; ch++) begin
            obs_tick[ch]   = 0;
            obs_wrap[ch]   = 0;
            obs_lvl_hi[ch] = 0;
        end
    endtask

    task automatic press(input int ch);
        sw[ch] = 1'b0;
        step(10);
        sw[ch] = 1'b1;
        step(10);
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        sw    = 2'b11;
        mode  = 4'b0101;
        db_en = 2'b11;
        clr   = 2'b00;
        step(3);
        rst_n = 1'b1;

        // 1: idle inputs through reset release
        clear_obs();
        step(20);
        check("t1 tick", tick, 0);
        check("t1 level", level, 0);
        check("t1 count_flat", count_flat, 8'h00);
        check("t1 tick pulses", obs_tick[0] + obs_tick[1], 0);

        // 2: clean press on ch0, rising mode
        clear_obs();
        sw[0] = 1'b0;
        k = 0;
        for (int c = 1; c <= 20; c++) begin
            step(1);
            if (level[0]) begin
                k = c;
                break;
            end
        end
        check("t2 level latency", k, 7);
        check("t2 tick on rise", tick[0], 1);
        step(1);
        check("t2 count0", count_flat[3:0], 1);
        step(2);
        sw[0] = 1'b1;
        step(12);
        check("t2 ticks total", obs_tick[0], 1);
        check("t2 level released", level[0], 0);

        // 3: bouncing input never settles long enough
        clear_obs();
        sw[0] = 1'b0; step(3);
        sw[0] = 1'b1; step(1);
        sw[0] = 1'b0; step(3);
        sw[0] = 1'b1; step(12);
        check("t3 level never high", obs_lvl_hi[0], 0);
        check("t3 count0 held", count_flat[3:0], 1);

        // 4: ch1 both edges, ten presses
        clear_obs();
        mode[3:2] = 2'b11;
        for (int p = 0; p < 10; p++) press(1);
        check("t4 ticks ch1", obs_tick[1], 20);
        check("t4 wraps ch1", obs_wrap[1], 2);
        check("t4 count1", count_flat[7:4], 0);

        // 5: clear beats tick at count 9; mode 00 suppresses ticks
        for (int p = 0; p < 8; p++) press(0);
        check("t5 count0 at 9", count_flat[3:0], 9);
        sw[0] = 1'b0;
        step(7);
        clr[0] = 1'b1;
        #1;
        check("t5 tick with clr", tick[0], 1);
        check("t5 wrap blocked", wrap[0], 0);
        step(1);
        clr[0] = 1'b0;
        check("t5 count0 cleared", count_flat[3:0], 0);
        sw[0] = 1'b1;
        step(12);
        clear_obs();
        mode[3:2] = 2'b00;
        press(1);
        check("t5 mode00 ticks", obs_tick[1], 0);
        check("t5 mode00 level moved", obs_lvl_hi[1] != 0, 1);

        // 6: bypass passes a 1-cycle glitch; reset during a debounce wait
        clear_obs();
        mode[3:2] = 2'b01;
        db_en[1]  = 1'b0;
        sw[1] = 1'b0; step(1);
        sw[1] = 1'b1; step(10);
        check("t6 bypass ticks", obs_tick[1], 1);
        check("t6 bypass count1", count_flat[7:4], 1);
        db_en[1] = 1'b1;
        step(2);
        sw[0] = 1'b0;
        step(4);
        rst_n = 1'b0;
        sw[0] = 1'b1;
        step(1);
        check("t6 reset level", level, 0);
        check("t6 reset tick", tick, 0);
        check("t6 reset wrap", wrap, 0);
        check("t6 reset count", count_flat, 0);
        rst_n = 1'b1;
        clear_obs();
        step(10);
        check("t6 quiet after reset", obs_tick[0] + obs_tick[1], 0);

        // Random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            for (int ch = 0; ch < N_CH; ch++)
                if ($urandom_range(0, 9) == 0) sw[ch] = ~sw[ch];
            if ($urandom_range(0, 63) == 0) mode = 4'($urandom);
            if ($urandom_range(0, 199) == 0) db_en = db_en ^ 2'($urandom_range(1, 3));
            clr   = ($urandom_range(0, 49) == 0) ? 2'($urandom) : 2'b00;
            rst_n = ($urandom_range(0, 1499) != 0);
            step(1);
        end
        rst_n = 1'b1;
        step(3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
